mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Target side of the CPU memory interface: two registered read ports and one byte-enabled write port.
- Paced by the CPU's clk_en pulse.
- Backs a word RAM plus a small MMIO page: console output FIFO, interval timer, interrupt-pending register.
- The `interrupts` output drives the CPU interrupt input.
- Sits beside pipelined_cpu at the top level.

Parameters:
- RAM_WORDS, 4096: RAM depth in 32-bit words. Byte address bits [13:2] index the RAM; higher bits alias modulo depth.
- FIFO_DEPTH, 8: console FIFO entries, power of two.
- MMIO_BASE, 18'h3FF00: base of the 256-byte MMIO page. The page is decoded on addr[17:8].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  CPU advance pulse; all interface state updates only when high
- rd0_addr  in  18  byte address, read port 0 (fetch)
- rd0_data  out  32  registered read data, port 0
- rd1_addr  in  18  byte address, read port 1 (load)
- rd1_data  out  32  registered read data, port 1
- we  in  4  write byte enables; bit i = byte lane i (bits 8i+7:8i)
- wr_addr  in  18  write byte address
- wr_data  in  32  write data
- con_valid  out  1  console FIFO head valid
- con_data  out  8  console FIFO head byte
- con_ready  in  1  console sink accepts head
- interrupts  out  16  pending-interrupt vector to CPU

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rd0_data, rd1_data = 0; interrupts = 0; con_valid = 0; con_data = 0.
  - FIFO empty; overflow flag = 0; TIMER_CNT = 0; TIMER_CMP = 0.
  - RAM contents are not reset.
- Address decode: bits [1:0] ignored (word access). A word is MMIO if addr[17:8] == MMIO_BASE[17:8]; otherwise RAM.
- Read (both ports independent):
  - On posedge clk with clk_en=1, rdN_data <= word at rdN_addr.
  - Read data holds between clk_en pulses (1 clk_en-cycle latency).
  - Reads of unmapped MMIO offsets return 0.
- Write: on posedge clk with clk_en=1, for each lane i with we[i]=1, byte i of the target word <= wr_data byte i. MMIO writes never modify RAM.
- MMIO map (byte offsets):
  - 0x00 CON: write (we[0]) pushes wr_data[7:0]. Read = {overflow, 27'b0, count[3:0]}.
  - 0x04 TIMER_CMP: read/write, 32 bits. A value of 0 disables the timer.
  - 0x08 TIMER_CNT: read/write, 32 bits.
  - 0x0C IRQ_PEND: read = {16'b0, pend}. Write-1-to-clear on pend[15:0].
- Console FIFO:
  - Pop occurs on any clk edge with con_valid & con_ready, independent of clk_en.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs the same edge.
  - Push when full with no pop: byte dropped, overflow <= 1 (sticky).
  - Overflow is cleared by a write to CON with wr_data[31]=1; in that case no byte is pushed.
  - con_data always shows the head entry. Push to an empty FIFO shows valid on the next edge.
- Timer (clk_en=1, CMP != 0):
  - If CNT == CMP-1: CNT <= 0 and pend[0] <= 1.
  - Otherwise CNT <= CNT+1.
  - A write to TIMER_CNT overrides the increment for that edge.
  - With CMP == 0, CNT holds.
- pend[1] <= 1 on the edge an overflow drop occurs.
- pend[15:2] = 0.
- If a set and a W1C clear hit the same pend bit on the same edge, the set wins.
- interrupts = pend (registered).
- A read and a write to the same word on the same edge: behaviour is governed by the Optional Feature.
- Reset asserted mid-operation clears all state immediately. Partial writes are not completed.

Optional Feature:
- WRITE_FORWARD_EN defined: a same-edge read of the word being written returns the merged data (written lanes new, others old). This applies to both RAM and MMIO registers.
- Undefined: such a read returns the pre-write contents (read-before-write).

Test Plan:
- RAM write/read: write 0xDEADBEEF to 0x00100 with we=4'hF, then read rd1_addr=0x00100 -> rd1_data = 0xDEADBEEF one clk_en later. Data holds across 3 idle clk cycles with clk_en=0.
- Byte lanes: 0x00100 holds 0xDEADBEEF; write 0x00005500 with we=4'b0010 -> read returns 0xDEAD55EF. rd0 and rd1 reading different addresses simultaneously return correct, independent data.
- Forwarding: write 0x11223344 to 0x00200 with rd0_addr=0x00200 on the same edge. Expect 0x11223344 with WRITE_FORWARD_EN; old contents without it.
- Console: with con_ready=0, push 'A'..'I' (9 bytes) -> count reads 8, overflow bit 31 = 1, interrupts[1] = 1. Raise con_ready -> 'A'..'H' drain in order, one per clk; con_valid then drops.
- Timer: CMP=3 with clk_en every cycle -> CNT counts 0,1,2,0 and interrupts[0] = 1 on the wrap edge. A W1C write of 0x1 on a wrap edge leaves the bit set; a W1C write of 0x1 on a non-wrap edge clears it.
- Reset: assert rst_n=0 mid-drain with FIFO count 5 and the timer running -> con_valid = 0, interrupts = 0, rd*_data = 0 immediately. After release, count reads 0 and CNT reads 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-interface target: word RAM plus an MMIO page (console FIFO, timer, IRQ pending).
// Define WRITE_FORWARD_EN to forward same-edge write data to a read of the same word.
module mem_responder #(
    parameter int unsigned RAM_WORDS  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [17:0] MMIO_BASE  = 18'h3FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [17:0] rd0_addr,
    output logic [31:0] rd0_data,
    input  logic [17:0] rd1_addr,
    output logic [31:0] rd1_data,
    input  logic [3:0]  we,
    input  logic [17:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic [15:0] interrupts
);
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [5:0] OffCon  = 6'd0;
    localparam logic [5:0] OffCmp  = 6'd1;
    localparam logic [5:0] OffCnt  = 6'd2;
    localparam logic [5:0] OffPend = 6'd3;

    logic [31:0]   mem [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [31:0]   tmr_cmp_q, tmr_cnt_q;
    logic [15:0]   pend_q, pend_d, pend_clr, pend_set;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdat[8*i +: 8];
        end
        return res;
    endfunction

    // Write-side decode
    logic          wr_act, wr_mmio;
    logic [5:0]    wr_off;
    logic [AW-1:0] wr_idx;
    assign wr_act  = clk_en && (we != 4'b0000);
    assign wr_mmio = wr_addr[17:8] == MMIO_BASE[17:8];
    assign wr_off  = wr_addr[7:2];
    assign wr_idx  = wr_addr[AW+1:2];

    logic con_wr, cmp_wr, cnt_wr, pend_wr;
    assign con_wr  = wr_act && wr_mmio && wr_off == OffCon && we[0];
    assign cmp_wr  = wr_act && wr_mmio && wr_off == OffCmp;
    assign cnt_wr  = wr_act && wr_mmio && wr_off == OffCnt;
    assign pend_wr = wr_act && wr_mmio && wr_off == OffPend;

    // Read-side decode, one entry per port
    logic          rd_mmio [2];
    logic [5:0]    rd_off  [2];
    logic [AW-1:0] rd_idx  [2];
    logic [31:0]   rd_word [2];
    assign rd_mmio[0] = rd0_addr[17:8] == MMIO_BASE[17:8];
    assign rd_mmio[1] = rd1_addr[17:8] == MMIO_BASE[17:8];
    assign rd_off[0]  = rd0_addr[7:2];
    assign rd_off[1]  = rd1_addr[7:2];
    assign rd_idx[0]  = rd0_addr[AW+1:2];
    assign rd_idx[1]  = rd1_addr[AW+1:2];

    logic unused_addr;
    assign unused_addr = ^{rd0_addr[1:0], rd1_addr[1:0], wr_addr[1:0]};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = 32'h0;
            if (rd_mmio[p]) begin
                case (rd_off[p])
                    OffCon:  rd_word[p] = {ovf_q, 31'(count_q)};
                    OffCmp:  rd_word[p] = tmr_cmp_q;
                    OffCnt:  rd_word[p] = tmr_cnt_q;
                    OffPend: rd_word[p] = {16'h0, pend_q};
                    default: rd_word[p] = 32'h0;
                endcase
            end else begin
                rd_word[p] = mem[rd_idx[p]];
            end
`ifdef WRITE_FORWARD_EN
            if (wr_act && rd_mmio[p] == wr_mmio &&
                (rd_mmio[p] ? rd_off[p] == wr_off : rd_idx[p] == wr_idx)) begin
                rd_word[p] = merge(rd_word[p], wr_data, we);
            end
`endif
        end
    end

    // Console FIFO; pops run off every clk edge, pushes only on clk_en
    logic pop, push_req, push_ok, drop, ovf_clr;
    assign con_valid = count_q != '0;
    assign con_data  = con_valid ? fifo[rptr_q] : 8'h00;
    assign pop       = con_valid && con_ready;
    assign ovf_clr   = con_wr && wr_data[31];
    assign push_req  = con_wr && !wr_data[31];
    assign push_ok   = push_req && (count_q < CW'(FIFO_DEPTH) || pop);
    assign drop      = push_req && !push_ok;

    logic wrap;
    assign wrap = clk_en && tmr_cmp_q != 32'h0 && tmr_cnt_q == tmr_cmp_q - 32'd1;

    always_comb begin
        pend_clr = 16'h0;
        if (pend_wr) begin
            pend_clr[7:0]  = we[0] ? wr_data[7:0]  : 8'h00;
            pend_clr[15:8] = we[1] ? wr_data[15:8] : 8'h00;
        end
        pend_set = {14'h0, drop, wrap};
        // Set beats clear on the same bit
        pend_d   = (pend_q & ~pend_clr) | pend_set;
    end

    assign interrupts = pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data  <= 32'h0;
            rd1_data  <= 32'h0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tmr_cmp_q <= 32'h0;
            tmr_cnt_q <= 32'h0;
            pend_q    <= 16'h0;
        end else begin
            if (clk_en) begin
                rd0_data <= rd_word[0];
                rd1_data <= rd_word[1];
            end
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if (ovf_clr)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
            if (cmp_wr) tmr_cmp_q <= merge(tmr_cmp_q, wr_data, we);
            if (cnt_wr)                              tmr_cnt_q <= merge(tmr_cnt_q, wr_data, we);
            else if (wrap)                           tmr_cnt_q <= 32'h0;
            else if (clk_en && tmr_cmp_q != 32'h0)   tmr_cnt_q <= tmr_cnt_q + 32'd1;
            pend_q <= pend_d;
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wptr_q] <= wr_data[7:0];
        if (wr_act && !wr_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (RAM, byte lanes, console FIFO, timer, reset).
module tb_mem_responder;
    localparam logic [17:0] ConA  = 18'h3FF00;
    localparam logic [17:0] CmpA  = 18'h3FF04;
    localparam logic [17:0] CntA  = 18'h3FF08;
    localparam logic [17:0] PendA = 18'h3FF0C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [17:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
    logic [31:0] rd0_data, rd1_data;
    logic [3:0]  we = '0;
    logic [31:0] wr_data = '0;
    logic        con_valid, con_ready = 1'b0;
    logic [7:0]  con_data;
    logic [15:0] interrupts;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .rd0_addr   (rd0_addr),
        .rd0_data   (rd0_data),
        .rd1_addr   (rd1_addr),
        .rd1_data   (rd1_data),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .con_valid  (con_valid),
        .con_data   (con_data),
        .con_ready  (con_ready),
        .interrupts (interrupts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_addr = a;
        wr_data = d;
        we      = be;
        clk_en  = 1'b1;
        tick();
        we      = 4'h0;
        clk_en  = 1'b0;
    endtask

    task automatic rd(input logic [17:0] a0, input logic [17:0] a1);
        rd0_addr = a0;
        rd1_addr = a1;
        clk_en   = 1'b1;
        tick();
        clk_en   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_rd0", rd0_data, 32'h0);
        check("rst_rd1", rd1_data, 32'h0);
        check("rst_irq", 32'(interrupts), 32'h0);
        check("rst_cvalid", 32'(con_valid), 32'h0);
        check("rst_cdata", 32'(con_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // RAM write/read and hold
        wr(18'h00100, 32'hDEADBEEF, 4'hF);
        rd(18'h0, 18'h00100);
        check("ram_rd", rd1_data, 32'hDEADBEEF);
        rd1_addr = 18'h00200;
        repeat (3) tick();
        check("ram_hold", rd1_data, 32'hDEADBEEF);

        // Byte lanes and independent ports
        wr(18'h00100, 32'h00005500, 4'b0010);
        wr(18'h00104, 32'h12345678, 4'hF);
        rd(18'h00100, 18'h00104);
        check("lane_rd0", rd0_data, 32'hDEAD55EF);
        check("lane_rd1", rd1_data, 32'h12345678);
        rd(18'h0, 18'h04100);
        check("alias", rd1_data, 32'hDEAD55EF);

        // Same-edge read/write
        wr(18'h00200, 32'hAAAAAAAA, 4'hF);
        rd0_addr = 18'h00200;
        wr(18'h00200, 32'h11223344, 4'hF);
`ifdef WRITE_FORWARD_EN
        check("fwd", rd0_data, 32'h11223344);
`else
        check("rbw", rd0_data, 32'hAAAAAAAA);
`endif
        rd(18'h00200, 18'h0);
        check("after_wr", rd0_data, 32'h11223344);

        // Console overflow and drain
        for (int i = 0; i < 9; i++) wr(ConA, 32'h41 + 32'(i), 4'h1);
        rd(18'h0, ConA);
        check("con_stat", rd1_data, 32'h80000008);
        check("ovf_irq", 32'(interrupts), 32'h2);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(con_valid), 32'h1);
            check("drain_data", 32'(con_data), 32'h41 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(con_valid), 32'h0);
        con_ready = 1'b0;
        wr(ConA, 32'h80000000, 4'h1);
        wr(PendA, 32'h2, 4'h1);
        rd(18'h0, ConA);
        check("ovf_clr", rd1_data, 32'h0);
        check("irq_clr", 32'(interrupts), 32'h0);

        // Timer with CMP=3
        wr(CmpA, 32'd3, 4'hF);
        rd0_addr = CntA;
        clk_en   = 1'b1;
        tick();
        check("cnt_0", rd0_data, 32'd0);
        check("irq_pre", 32'(interrupts), 32'h0);
        tick();
        check("cnt_1", rd0_data, 32'd1);
        tick();
        check("cnt_2", rd0_data, 32'd2);
        check("irq_wrap", 32'(interrupts), 32'h1);
        tick();
        check("cnt_wrap", rd0_data, 32'd0);
        tick();
        wr_addr = PendA;
        wr_data = 32'h1;
        we      = 4'h1;
        tick();
        check("w1c_set_wins", 32'(interrupts), 32'h1);
        tick();
        check("w1c_clear", 32'(interrupts), 32'h0);
        we     = 4'h0;
        clk_en = 1'b0;

        // Reset mid-drain
        for (int i = 0; i < 6; i++) wr(ConA, 32'h61 + 32'(i), 4'h1);
        rd(18'h00100, 18'h00100);
        check("pre_rst_rd0", rd0_data, 32'hDEAD55EF);
        con_ready = 1'b1;
        tick();
        check("pre_rst_head", 32'(con_data), 32'h62);
        #2 rst_n = 1'b0;
        #1;
        check("async_cvalid", 32'(con_valid), 32'h0);
        check("async_irq", 32'(interrupts), 32'h0);
        check("async_rd0", rd0_data, 32'h0);
        check("async_rd1", rd1_data, 32'h0);
        con_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rd(CntA, ConA);
        check("post_cnt", rd0_data, 32'h0);
        check("post_con", rd1_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
